// File: rtl/cordic_ahb_pkg.sv
// Shared AHB-Lite encodings, CORDIC slave register map and master FSM states.
package cordic_ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [ADDR_W-1:0] CORDIC_STATUS_ADDR = 32'h4001_0000;
  localparam logic [ADDR_W-1:0] CORDIC_DATA_ADDR   = 32'h4001_0004;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Anything wider than a word is not supported on this 32-bit bus.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    case (size)
      HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD: clamp_size = size;
      default:                            clamp_size = HSIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/cordic_ahb_master.sv
// Single-outstanding AHB-Lite master: one write or (optionally polled) read
// per local command, with a registered one-cycle response.
module cordic_ahb_master
  import cordic_ahb_pkg::*;
#(
  parameter int unsigned POLL_MAX  = 16,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_poll,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA
);

  localparam int unsigned CNT_W = $clog2(POLL_MAX + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          size_q, size_d;
  logic                write_q, write_d;
  logic                poll_q, poll_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      poll_q      <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      write_q     <= write_d;
      poll_q      <= poll_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    write_d     = write_q;
    poll_d      = poll_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          size_d  = clamp_size(cmd_size);
          write_d = cmd_write;
          poll_d  = cmd_poll & ~cmd_write;
          cnt_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (HREADY) begin
          // Resolve the completed data phase: finish, or re-issue a poll read.
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = HRESP;
          rsp_rdata_d = write_q ? '0 : HRDATA;
          if (!HRESP && poll_q && !HRDATA[0]) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(POLL_MAX - 1)) begin
              rsp_err_d = 1'b1;
            end else begin
              rsp_valid_d = 1'b0;
              state_d     = ST_ADDR;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HTRANS    = HTRANS_IDLE;
    cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_ADDR: HTRANS    = HTRANS_NONSEQ;
      default: ;
    endcase
  end

  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HSIZE     = size_q;
  assign HWDATA    = wdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_cordic_ahb_master.sv
// Directed bench for cordic_ahb_master with a hand-driven AHB-Lite slave.
module tb_cordic_ahb_master;
  import cordic_ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_write, cmd_poll;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        HREADY, HRESP;
  logic [31:0] HRDATA;
  logic        cmd_ready, rsp_valid, rsp_err, HWRITE, HMASTLOCK;
  logic [31:0] rsp_rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int vecs = 0;
  int errs = 0;

  cordic_ahb_master #(.POLL_MAX(4), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_poll(cmd_poll), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  // Address/control must not move while an address phase is stalled.
  assert property (@(posedge HCLK) disable iff (!HRESETn)
    (HTRANS == 2'b10 && !HREADY) |=>
      (HTRANS == 2'b10 && $stable(HADDR) && $stable(HWRITE) && $stable(HSIZE)))
  else begin
    errs++;
    $display("FAIL addr_hold HTRANS=%b HADDR=%h", HTRANS, HADDR);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic p, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_poll = p;
    cmd_addr = a; cmd_size = s; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Poll stimulus: HRDATA[0] rises once 'hit' address phases were seen (0 = never).
  task automatic run_poll(input int hit, output int nseq, output bit got,
                          output logic [31:0] rdata, output logic err);
    nseq = 0; got = 1'b0; rdata = '0; err = 1'b0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    issue(1'b0, 1'b1, CORDIC_STATUS_ADDR, 3'b010, 32'h0);
    for (int c = 0; c < 40 && !got; c++) begin
      if (HTRANS == 2'b10) nseq++;
      if (rsp_valid) begin
        got = 1'b1; rdata = rsp_rdata; err = rsp_err;
      end else begin
        HRDATA = (hit != 0 && nseq >= hit) ? 32'h1 : 32'h0;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_poll = 1'b0;
    cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    tick(); tick();
    vecs++; if (HTRANS !== 2'b00) begin errs++; $display("FAIL reset_htrans got=%b exp=00", HTRANS); end
    vecs++; if (HADDR !== 32'h0 || HWDATA !== 32'h0) begin errs++; $display("FAIL reset_bus got=%h/%h exp=0/0", HADDR, HWDATA); end
    vecs++; if (HWRITE !== 1'b0 || HSIZE !== 3'b000) begin errs++; $display("FAIL reset_ctrl got=%b/%b exp=0/000", HWRITE, HSIZE); end
    vecs++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL reset_rsp got=%b/%b/%h exp=0/0/0", rsp_valid, rsp_err, rsp_rdata); end
    vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    vecs++; if (HBURST !== 3'b000 || HMASTLOCK !== 1'b0 || HPROT !== 4'b0011) begin errs++; $display("FAIL reset_const got=%b/%b/%b exp=000/0/0011", HBURST, HMASTLOCK, HPROT); end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    issue(1'b1, 1'b0, CORDIC_DATA_ADDR, 3'b010, 32'h3F80_0000);
    vecs++; if (HTRANS !== 2'b10 || HADDR !== 32'h4001_0004 || HWRITE !== 1'b1 || HSIZE !== 3'b010)
      begin errs++; $display("FAIL wr_addr got=%b/%h/%b/%b exp=10/40010004/1/010", HTRANS, HADDR, HWRITE, HSIZE); end
    vecs++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL wr_busy got=%b exp=0", cmd_ready); end
    tick();
    vecs++; if (HTRANS !== 2'b00 || HWDATA !== 32'h3F80_0000 || rsp_valid !== 1'b0)
      begin errs++; $display("FAIL wr_data got=%b/%h/%b exp=00/3f800000/0", HTRANS, HWDATA, rsp_valid); end
    tick();
    vecs++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b1)
      begin errs++; $display("FAIL wr_rsp got=%b/%b/%h/%b exp=1/0/0/1", rsp_valid, rsp_err, rsp_rdata, cmd_ready); end
    tick();
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL wr_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_read_wait();
    HREADY = 1'b1; HRDATA = 32'h1111_1111;
    issue(1'b0, 1'b0, CORDIC_DATA_ADDR, 3'b010, 32'h0);
    tick();
    HREADY = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vecs++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0)
        begin errs++; $display("FAIL rd_wait%0d got=%b/%b exp=00/0", c, HTRANS, rsp_valid); end
      tick();
    end
    HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF;
    vecs++; if (HTRANS !== 2'b00) begin errs++; $display("FAIL rd_last got=%b exp=00", HTRANS); end
    tick();
    HRDATA = 32'h0;
    vecs++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0)
      begin errs++; $display("FAIL rd_rsp got=%b/%h/%b exp=1/deadbeef/0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    issue(1'b0, 1'b0, 32'h4001_0008, 3'b000, 32'h0);
    vecs++; if (HSIZE !== 3'b000) begin errs++; $display("FAIL b2b_byte got=%b exp=000", HSIZE); end
    tick(); tick();
    vecs++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || cmd_ready !== 1'b1)
      begin errs++; $display("FAIL b2b_rsp1 got=%b/%h/%b exp=1/12345678/1", rsp_valid, rsp_rdata, cmd_ready); end
    HRDATA = 32'h0;
    issue(1'b1, 1'b1, CORDIC_DATA_ADDR, 3'b111, 32'hCAFE_F00D);
    vecs++; if (HTRANS !== 2'b10 || HSIZE !== 3'b010 || HWRITE !== 1'b1 || rsp_valid !== 1'b0)
      begin errs++; $display("FAIL b2b_addr got=%b/%b/%b/%b exp=10/010/1/0", HTRANS, HSIZE, HWRITE, rsp_valid); end
    tick(); tick();
    vecs++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      begin errs++; $display("FAIL b2b_rsp2 got=%b/%h/%b exp=1/0/0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
  endtask

  task automatic test_addr_wait();
    HREADY = 1'b1;
    issue(1'b1, 1'b0, 32'h4001_000C, 3'b001, 32'hA5A5_5A5A);
    HREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vecs++; if (HTRANS !== 2'b10 || HADDR !== 32'h4001_000C || HSIZE !== 3'b001)
        begin errs++; $display("FAIL aw_hold%0d got=%b/%h/%b exp=10/4001000c/001", c, HTRANS, HADDR, HSIZE); end
      tick();
    end
    HREADY = 1'b1;
    vecs++; if (HTRANS !== 2'b10) begin errs++; $display("FAIL aw_last got=%b exp=10", HTRANS); end
    tick(); tick();
    vecs++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errs++; $display("FAIL aw_rsp got=%b/%b exp=1/0", rsp_valid, rsp_err); end
    tick();
  endtask

  task automatic test_poll();
    int nseq; bit got; logic [31:0] rd; logic er;
    run_poll(3, nseq, got, rd, er);
    vecs++; if (!got) begin errs++; $display("FAIL poll_timeout got=no_rsp exp=rsp"); end
    vecs++; if (nseq != 3) begin errs++; $display("FAIL poll_nseq got=%0d exp=3", nseq); end
    vecs++; if (rd !== 32'h1 || er !== 1'b0) begin errs++; $display("FAIL poll_rsp got=%h/%b exp=1/0", rd, er); end
    tick();
    HRDATA = 32'h0;
    vecs++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin errs++; $display("FAIL poll_after got=%b/%b exp=0/00", rsp_valid, HTRANS); end
    run_poll(0, nseq, got, rd, er);
    vecs++; if (!got) begin errs++; $display("FAIL pmax_timeout got=no_rsp exp=rsp"); end
    vecs++; if (nseq != 4) begin errs++; $display("FAIL pmax_nseq got=%0d exp=4", nseq); end
    vecs++; if (rd !== 32'h0 || er !== 1'b1) begin errs++; $display("FAIL pmax_rsp got=%h/%b exp=0/1", rd, er); end
    tick();
  endtask

  task automatic test_error();
    int extra = 0;
    HREADY = 1'b1; HRESP = 1'b0;
    issue(1'b1, 1'b0, CORDIC_DATA_ADDR, 3'b010, 32'h4000_0000);
    tick();
    HREADY = 1'b0; HRESP = 1'b1;
    vecs++; if (HTRANS !== 2'b00) begin errs++; $display("FAIL err_first got=%b exp=00", HTRANS); end
    tick();
    HREADY = 1'b1;
    vecs++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errs++; $display("FAIL err_second got=%b/%b exp=00/0", HTRANS, rsp_valid); end
    tick();
    HRESP = 1'b0;
    vecs++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errs++; $display("FAIL err_rsp got=%b/%b exp=1/1", rsp_valid, rsp_err); end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (HTRANS == 2'b10 || rsp_valid) extra++;
    end
    vecs++; if (extra != 0) begin errs++; $display("FAIL err_retry got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    HREADY = 1'b1; HRDATA = 32'h7777_7777;
    issue(1'b0, 1'b0, CORDIC_DATA_ADDR, 3'b010, 32'h0);
    tick();
    HREADY = 1'b0; HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1; HREADY = 1'b1;
    vecs++; if (HTRANS !== 2'b00 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      begin errs++; $display("FAIL rst_mid got=%b/%b/%b exp=00/1/0", HTRANS, cmd_ready, rsp_valid); end
    tick(); tick();
    vecs++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin errs++; $display("FAIL rst_quiet got=%b/%b exp=0/00", rsp_valid, HTRANS); end
    issue(1'b1, 1'b0, CORDIC_DATA_ADDR, 3'b010, 32'h0BAD_F00D);
    tick();
    vecs++; if (HWDATA !== 32'h0BAD_F00D) begin errs++; $display("FAIL rst_wdata got=%h exp=0badf00d", HWDATA); end
    tick();
    vecs++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errs++; $display("FAIL rst_newcmd got=%b/%b exp=1/0", rsp_valid, rsp_err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_addr_wait();
    test_poll();
    test_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cordic_ahb_master.md
Name: cordic_ahb_master

Overview:
Single-outstanding AHB-Lite master that lets a local command port (test sequencer or control FSM) drive the CORDIC AHB-Lite slave. It performs single writes of operands and single reads of results. An optional poll mode re-reads the status word at 0x40010000 until bit 0 reads 1 (FIFO non-empty) or a retry limit expires. It sits between the local controller and the AHB-Lite fabric, as the initiator for the CORDIC slave.

Parameters:
POLL_MAX, 16, maximum read attempts in poll mode (≥1)
HPROT_VAL, 4'b0011, constant driven on HPROT

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset; one clock; reset is synchronous and active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; handshake when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_poll  in  1  read only: repeat until HRDATA[0]==1
cmd_addr  in  32  byte address
cmd_size  in  3  HSIZE value; values >3'b010 clamp to 3'b010
cmd_wdata  in  32  write data
rsp_valid  out  1  one-cycle pulse, command finished
rsp_rdata  out  32  last sampled HRDATA (reads); 0 for writes
rsp_err  out  1  HRESP error or poll timeout; valid with rsp_valid
HADDR  out  32  address
HTRANS  out  2  IDLE=00, NONSEQ=10 only
HWRITE  out  1  direction
HSIZE  out  3  transfer size
HBURST  out  3  constant 3'b000 (SINGLE)
HMASTLOCK  out  1  constant 0
HPROT  out  4  HPROT_VAL
HWDATA  out  32  write data, valid in the data phase
HREADY  in  1  transfer-complete indication from the fabric
HRESP  in  1  0 = OKAY, 1 = ERROR
HRDATA  in  32  read data

Behaviour:
- Reset (sampled on the HCLK edge with HRESETn=0): state IDLE; HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0; rsp_valid=0, rsp_rdata=0, rsp_err=0; poll counter=0.
- cmd_ready = (state==IDLE), so it reads 1 after the reset edge. Reset mid-transfer aborts unconditionally, with no response.
- States:
  - IDLE: on handshake, latch addr/size/write/wdata/poll and go to ADDR.
  - ADDR: HTRANS=NONSEQ with HADDR/HWRITE/HSIZE driven. If HREADY=1, go to DATA. If HREADY=0, stay in ADDR and hold all address/control signals stable.
  - DATA: HTRANS=IDLE; HWDATA held. Stay in DATA while HREADY=0. When HREADY=1, sample HRDATA and HRESP, then resolve:
    - HRESP=1: rsp_valid, rsp_err=1, go to IDLE.
    - Write, or read without poll: rsp_valid, rsp_err=0, go to IDLE.
    - Poll read with HRDATA[0]=1: rsp_valid, rsp_rdata=HRDATA, err=0, go to IDLE.
    - Poll read with HRDATA[0]=0 and attempts < POLL_MAX: increment counter, go to ADDR (new NONSEQ next cycle).
    - Poll read with HRDATA[0]=0 and attempts == POLL_MAX: rsp_valid, rsp_err=1, rsp_rdata=last HRDATA, go to IDLE.
- Responses are registered: rsp_valid goes high in the cycle after the completing HREADY and coincides with the return to IDLE. A new command may therefore be accepted in the same cycle rsp_valid is high.
- Zero-wait latency: accept at cycle 0, NONSEQ at cycle 1, data phase at cycle 2, rsp_valid at cycle 3. Each wait state adds one cycle.
- The first ERROR cycle (HREADY=0, HRESP=1) is treated as a wait state. The master never issues a transfer during it, because DATA already drives HTRANS=IDLE.
- cmd_poll with cmd_write=1: poll is ignored and the command is a plain write.
- The poll counter resets on each accepted command; it counts completed read attempts.
- No transfers are pipelined: the next address phase never overlaps a data phase.

Decomposition:
- Shared package cordic_ahb_pkg holds:
  - HTRANS_IDLE / HTRANS_NONSEQ, HSIZE_BYTE / HALF / WORD, HBURST_SINGLE.
  - State encoding (IDLE, ADDR, DATA).
  - CORDIC_STATUS_ADDR=32'h40010000 and CORDIC_DATA_ADDR=32'h40010004.
- No sub-module: a single FSM plus poll counter.

Test Plan:
- Write 0x3F800000 to 0x40010004, size 010, HREADY always 1 -> NONSEQ at cycle 1, HWDATA=0x3F800000 at cycle 2, rsp_valid at cycle 3 with err=0 and rdata=0.
- Read 0x40010004 with HREADY low for 2 data-phase cycles, HRDATA=0xDEADBEEF -> rsp at cycle 5 with rsp_rdata=0xDEADBEEF; HTRANS=IDLE throughout the data phase.
- Poll 0x40010000 with HRDATA[0] sequence 0,0,1 -> exactly 3 NONSEQ phases, one rsp_valid, rdata=1, err=0.
- Poll with POLL_MAX=4 and HRDATA always 0 -> 4 NONSEQ phases, then rsp_err=1, rdata=0.
- Slave gives a 2-cycle ERROR (HREADY 0/1, HRESP 1/1) on a write -> rsp_err=1, no retry, no further NONSEQ.
- HRESETn=0 asserted while in DATA with HREADY low -> next cycle HTRANS=00, cmd_ready=1, no rsp_valid; a new command then completes normally.
- Address held stable in ADDR while HREADY=0 for 3 cycles (checked with an assertion).
